s_term_gen: RTL and testbench

S_TERM_GEN -- requirements
Module: s_term_gen

---
 rtl/s_term_gen_if.sv | 28 ++
 rtl/s_term_gen.sv | 163 ++++++++++++++++
 tb/tb_s_term_gen.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_term_gen_if.sv
// South-to-north wire bundle of the S-terminal tile.
// The master side drives the south wire ends; the slave (the tile) drives the north wire begins.
interface s_term_gen_if #(
   parameter int W1 = 4,
   parameter int W2 = 8,
   parameter int W4 = 16
);
   logic [W1-1:0] S1END;
   logic [W2-1:0] S2MID;
   logic [W2-1:0] S2END;
   logic [W4-1:0] S4END;
   logic [W4-1:0] SS4END;
   logic [W1-1:0] N1BEG;
   logic [W2-1:0] N2BEG;
   logic [W2-1:0] N2BEGb;
   logic [W4-1:0] N4BEG;
   logic [W4-1:0] NN4BEG;

   modport master (
      output S1END, S2MID, S2END, S4END, SS4END,
      input  N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG
   );

   modport slave (
      input  S1END, S2MID, S2END, S4END, SS4END,
      output N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG
   );
endinterface

// File: rtl/s_term_gen.sv
// S-terminal tile: loops south wire ends back north under a 10-bit mode register.
// The mode register is loaded from frame data on the rising edge of a selected frame strobe.
module s_term_gen_clkbuf (
   input  logic clk,
   output logic clk_buf
);
   // Behavioural model of the technology clock buffer cell: a pure wire with no logic.
   assign clk_buf = clk;
endmodule

module s_term_gen_loop #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   mode,
   input  logic [W-1:0] src,
   output logic [W-1:0] dst
);
   logic [W-1:0] src_q;

   // Always tracks the source, so switching to mode 11 never exposes stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q <= '0;
      end else begin
         src_q <= src;
      end
   end

   always_comb begin
      dst = '0;
      case (mode)
         2'b01:   dst = src;
         2'b10:   dst = ~src;
         2'b11:   dst = src_q;
         default: dst = '0;
      endcase
   end
endmodule

module s_term_gen #(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int W1              = 4,
   parameter int W2              = 8,
   parameter int W4              = 16,
   parameter int STROBE_PIPE     = 0,
   parameter int CFG_FRAME       = 0
) (
   input  logic                       UserCLK,
   input  logic                       UserRST,
   output logic                       UserCLKo,
   input  logic [FrameBitsPerRow-1:0] FrameData,
   input  logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
   s_term_gen_if.slave                wires,
   output logic                       CfgLoaded
);
   if (STROBE_PIPE < 0 || STROBE_PIPE > 3) begin : g_bad_pipe
      $error("s_term_gen: STROBE_PIPE must be within 0..3");
   end
   if (CFG_FRAME < 0 || CFG_FRAME >= MaxFramesPerCol) begin : g_bad_frame
      $error("s_term_gen: CFG_FRAME must be within 0..MaxFramesPerCol-1");
   end
   if (FrameBitsPerRow < 10) begin : g_bad_width
      $error("s_term_gen: FrameBitsPerRow must be at least 10");
   end

   s_term_gen_clkbuf u_clkbuf (
      .clk     (UserCLK),
      .clk_buf (UserCLKo)
   );

   logic [9:0] cfg;
   logic       strobe_q;
   logic       strobe_now;
   logic       capture;

   assign strobe_now = FrameStrobe[CFG_FRAME];
   assign capture    = strobe_now & ~strobe_q;

   // strobe_q resets high so a strobe already asserted at reset release is not a new edge.
   always_ff @(posedge UserCLK) begin
      if (UserRST) begin
         cfg       <= '0;
         CfgLoaded <= 1'b0;
         strobe_q  <= 1'b1;
      end else begin
         strobe_q <= strobe_now;
         if (capture) begin
            cfg       <= FrameData[9:0];
            CfgLoaded <= 1'b1;
         end
      end
   end

   if (FrameBitsPerRow > 10) begin : g_spare_data
      logic unused_frame_bits;
      assign unused_frame_bits = ^FrameData[FrameBitsPerRow-1:10];
   end

   if (STROBE_PIPE == 0) begin : g_strobe_direct
      assign FrameStrobe_O = FrameStrobe;
   end else begin : g_strobe_pipe
      logic [MaxFramesPerCol-1:0] stage [STROBE_PIPE];

      always_ff @(posedge UserCLK) begin
         if (UserRST) begin
            for (int i = 0; i < STROBE_PIPE; i++) begin
               stage[i] <= '0;
            end
         end else begin
            stage[0] <= FrameStrobe;
            for (int i = 1; i < STROBE_PIPE; i++) begin
               stage[i] <= stage[i-1];
            end
         end
      end

      assign FrameStrobe_O = stage[STROBE_PIPE-1];
   end

   s_term_gen_loop #(.W(W1)) u_g0 (
      .clk  (UserCLK),
      .rst  (UserRST),
      .mode (cfg[1:0]),
      .src  (wires.S1END),
      .dst  (wires.N1BEG)
   );

   s_term_gen_loop #(.W(W2)) u_g1 (
      .clk  (UserCLK),
      .rst  (UserRST),
      .mode (cfg[3:2]),
      .src  (wires.S2MID),
      .dst  (wires.N2BEG)
   );

   s_term_gen_loop #(.W(W2)) u_g2 (
      .clk  (UserCLK),
      .rst  (UserRST),
      .mode (cfg[5:4]),
      .src  (wires.S2END),
      .dst  (wires.N2BEGb)
   );

   s_term_gen_loop #(.W(W4)) u_g3 (
      .clk  (UserCLK),
      .rst  (UserRST),
      .mode (cfg[7:6]),
      .src  (wires.S4END),
      .dst  (wires.N4BEG)
   );

   s_term_gen_loop #(.W(W4)) u_g4 (
      .clk  (UserCLK),
      .rst  (UserRST),
      .mode (cfg[9:8]),
      .src  (wires.SS4END),
      .dst  (wires.NN4BEG)
   );
endmodule

// File: tb/tb_s_term_gen.sv
// Scoreboard bench: dut_a is full width with a 2-stage strobe pipe, dut_b is reduced width with CFG_FRAME=3.
// Stimulus pushes one expectation per cycle; the monitor pops and compares at each falling edge.
module tb_s_term_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] frame_data;
   logic [19:0] frame_strobe;
   logic [19:0] strobe_o_a;
   logic [19:0] strobe_o_b;
   logic        clko_a;
   logic        clko_b;
   logic        loaded_a;
   logic        loaded_b;
   logic [3:0]  s1;
   logic [7:0]  s2m;
   logic [7:0]  s2e;
   logic [15:0] s4;
   logic [15:0] ss4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   s_term_gen_if #(.W1(4), .W2(8), .W4(16)) bus_a ();
   s_term_gen_if #(.W1(2), .W2(4), .W4(8))  bus_b ();

   assign bus_a.S1END  = s1;
   assign bus_a.S2MID  = s2m;
   assign bus_a.S2END  = s2e;
   assign bus_a.S4END  = s4;
   assign bus_a.SS4END = ss4;
   assign bus_b.S1END  = s1[1:0];
   assign bus_b.S2MID  = s2m[3:0];
   assign bus_b.S2END  = s2e[3:0];
   assign bus_b.S4END  = s4[7:0];
   assign bus_b.SS4END = ss4[7:0];

   s_term_gen #(.STROBE_PIPE(2), .CFG_FRAME(0)) dut_a (
      .UserCLK       (clk),
      .UserRST       (rst),
      .UserCLKo      (clko_a),
      .FrameData     (frame_data),
      .FrameStrobe   (frame_strobe),
      .FrameStrobe_O (strobe_o_a),
      .wires         (bus_a.slave),
      .CfgLoaded     (loaded_a)
   );

   s_term_gen #(.W1(2), .W2(4), .W4(8), .STROBE_PIPE(0), .CFG_FRAME(3)) dut_b (
      .UserCLK       (clk),
      .UserRST       (rst),
      .UserCLKo      (clko_b),
      .FrameData     (frame_data),
      .FrameStrobe   (frame_strobe),
      .FrameStrobe_O (strobe_o_b),
      .wires         (bus_b.slave),
      .CfgLoaded     (loaded_b)
   );

   typedef struct {
      string       name;
      bit          chk_a;
      bit          chk_b;
      bit          chk_pipe;
      logic [3:0]  n1;
      logic [7:0]  n2;
      logic [7:0]  n2b;
      logic [15:0] n4;
      logic [15:0] nn4;
      logic        loaded_a;
      logic [1:0]  rn1;
      logic [3:0]  rn2;
      logic [3:0]  rn2b;
      logic [7:0]  rn4;
      logic [7:0]  rnn4;
      logic        loaded_b;
      logic [19:0] strobe_a;
      logic [19:0] strobe_b;
   } exp_t;

   exp_t sb[$];
   exp_t next_exp;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic set_src(input logic [3:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [15:0] d, input logic [15:0] e);
      s1  = a;
      s2m = b;
      s2e = c;
      s4  = d;
      ss4 = e;
   endtask

   task automatic expect_a(input logic [3:0] n1, input logic [7:0] n2, input logic [7:0] n2b,
                           input logic [15:0] n4, input logic [15:0] nn4, input logic ld);
      next_exp.chk_a    = 1'b1;
      next_exp.n1       = n1;
      next_exp.n2       = n2;
      next_exp.n2b      = n2b;
      next_exp.n4       = n4;
      next_exp.nn4      = nn4;
      next_exp.loaded_a = ld;
   endtask

   task automatic expect_b(input logic [1:0] n1, input logic [3:0] n2, input logic [3:0] n2b,
                           input logic [7:0] n4, input logic [7:0] nn4, input logic ld);
      next_exp.chk_b    = 1'b1;
      next_exp.rn1      = n1;
      next_exp.rn2      = n2;
      next_exp.rn2b     = n2b;
      next_exp.rn4      = n4;
      next_exp.rnn4     = nn4;
      next_exp.loaded_b = ld;
   endtask

   task automatic expect_pipe(input logic [19:0] v);
      next_exp.chk_pipe = 1'b1;
      next_exp.strobe_a = v;
   endtask

   task automatic applyStimulus(input string name);
      next_exp.name     = name;
      next_exp.strobe_b = frame_strobe;
      sb.push_back(next_exp);
      next_exp.chk_a    = 1'b0;
      next_exp.chk_b    = 1'b0;
      next_exp.chk_pipe = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, " clko_a"}, 32'(clko_a), 32'(clk));
            checkOutput({e.name, " clko_b"}, 32'(clko_b), 32'(clk));
            checkOutput({e.name, " strobe_o_b"}, 32'(strobe_o_b), 32'(e.strobe_b));
            if (e.chk_pipe) begin
               checkOutput({e.name, " strobe_o_a"}, 32'(strobe_o_a), 32'(e.strobe_a));
            end
            if (e.chk_a) begin
               checkOutput({e.name, " a.N1BEG"}, 32'(bus_a.N1BEG), 32'(e.n1));
               checkOutput({e.name, " a.N2BEG"}, 32'(bus_a.N2BEG), 32'(e.n2));
               checkOutput({e.name, " a.N2BEGb"}, 32'(bus_a.N2BEGb), 32'(e.n2b));
               checkOutput({e.name, " a.N4BEG"}, 32'(bus_a.N4BEG), 32'(e.n4));
               checkOutput({e.name, " a.NN4BEG"}, 32'(bus_a.NN4BEG), 32'(e.nn4));
               checkOutput({e.name, " a.CfgLoaded"}, 32'(loaded_a), 32'(e.loaded_a));
            end
            if (e.chk_b) begin
               checkOutput({e.name, " b.N1BEG"}, 32'(bus_b.N1BEG), 32'(e.rn1));
               checkOutput({e.name, " b.N2BEG"}, 32'(bus_b.N2BEG), 32'(e.rn2));
               checkOutput({e.name, " b.N2BEGb"}, 32'(bus_b.N2BEGb), 32'(e.rn2b));
               checkOutput({e.name, " b.N4BEG"}, 32'(bus_b.N4BEG), 32'(e.rn4));
               checkOutput({e.name, " b.NN4BEG"}, 32'(bus_b.NN4BEG), 32'(e.rnn4));
               checkOutput({e.name, " b.CfgLoaded"}, 32'(loaded_b), 32'(e.loaded_b));
            end
         end
      end
   end

   initial begin : stimulus
      logic [9:0] hold_vals [4];
      hold_vals = '{10'h2AA, 10'h3FF, 10'h000, 10'h0AA};
      next_exp     = '{default: '0, name: ""};
      rst          = 1'b1;
      frame_data   = '0;
      frame_strobe = '0;
      set_src(4'h9, 8'h3C, 8'hA6, 16'h1234, 16'hA5A5);
      repeat (2) @(posedge clk);
      #1;

      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      expect_b(2'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      expect_pipe(20'h0);
      applyStimulus("reset");

      rst = 1'b0;
      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      expect_pipe(20'h0);
      applyStimulus("idle_after_reset");

      // Modes G4..G0 = 11,10,01,00,01 with SS4END=A5A5 at the capture cycle.
      frame_strobe = 20'h00081;
      frame_data   = 32'h0000_0391;
      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      expect_b(2'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      expect_pipe(20'h0);
      applyStimulus("capture_cycle");

      frame_strobe = '0;
      frame_data   = '0;
      set_src(4'h6, 8'hC3, 8'h5B, 16'hFEDC, 16'h5A5A);
      expect_a(4'h6, 8'h00, 8'h5B, 16'h0123, 16'hA5A5, 1'b1);
      expect_b(2'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      expect_pipe(20'h0);
      applyStimulus("modes_t1");

      expect_a(4'h6, 8'h00, 8'h5B, 16'h0123, 16'h5A5A, 1'b1);
      expect_pipe(20'h00081);
      applyStimulus("modes_t2");

      expect_a(4'h6, 8'h00, 8'h5B, 16'h0123, 16'h5A5A, 1'b1);
      expect_pipe(20'h0);
      applyStimulus("pipe_t3");

      frame_strobe = 20'h00001;
      frame_data   = 32'hFFFF_F155;
      expect_a(4'h6, 8'h00, 8'h5B, 16'h0123, 16'h5A5A, 1'b1);
      applyStimulus("hold_first");

      for (int i = 0; i < 4; i++) begin
         frame_data = 32'hFFFF_F000 | 32'(hold_vals[i]);
         expect_a(4'h6, 8'hC3, 8'h5B, 16'hFEDC, 16'h5A5A, 1'b1);
         applyStimulus("hold_later");
      end

      frame_strobe = '0;
      frame_data   = 32'h0000_02AA;
      expect_a(4'h6, 8'hC3, 8'h5B, 16'hFEDC, 16'h5A5A, 1'b1);
      applyStimulus("strobe_low");

      frame_strobe = 20'h00008;
      expect_a(4'h6, 8'hC3, 8'h5B, 16'hFEDC, 16'h5A5A, 1'b1);
      expect_b(2'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      applyStimulus("b_capture_cycle");

      frame_strobe = '0;
      frame_data   = '0;
      expect_a(4'h6, 8'hC3, 8'h5B, 16'hFEDC, 16'h5A5A, 1'b1);
      expect_b(2'b01, 4'hC, 4'h4, 8'h23, 8'hA5, 1'b1);
      applyStimulus("b_invert_1");

      set_src(4'h1, 8'h00, 8'hFF, 16'h00F0, 16'h0F0F);
      expect_a(4'h1, 8'h00, 8'hFF, 16'h00F0, 16'h0F0F, 1'b1);
      expect_b(2'b10, 4'hF, 4'h0, 8'h0F, 8'hF0, 1'b1);
      applyStimulus("b_invert_2");

      rst          = 1'b1;
      frame_strobe = 20'h00001;
      frame_data   = 32'h0000_02AA;
      expect_a(4'h1, 8'h00, 8'hFF, 16'h00F0, 16'h0F0F, 1'b1);
      applyStimulus("reset_with_capture");

      rst = 1'b0;
      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      expect_b(2'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      expect_pipe(20'h0);
      applyStimulus("after_reset");

      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      applyStimulus("held_no_capture");

      frame_strobe = '0;
      expect_a(4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0);
      applyStimulus("strobe_released");

      for (int i = 0; i < 5 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
